// File: rtl/interrupt_sequencer_if.sv
// Memory bus used by the interrupt sequencer: address, write data, direction,
// ready handshake and read data for the vector fetches.
interface interrupt_sequencer_if;
    logic [15:0] addr_out;
    logic [7:0]  data_out;
    logic        rw;
    logic        ready;
    logic [7:0]  data_in;

    modport master (
        output addr_out,
        output data_out,
        output rw,
        input  ready,
        input  data_in
    );

    modport slave (
        input  addr_out,
        input  data_out,
        input  rw,
        output ready,
        output data_in
    );
endinterface

// File: rtl/interrupt_sequencer.sv
// 6502-style interrupt entry: push PCH/PCL/P, set I, fetch the vector and load the PC.
// Outputs decode from registered state only; the sp_dec/set_i pulses are registered copies of the advance.
//
// state    | meaning
// IDLE     | bus released, waiting for an accepted request at an instruction boundary
// PUSH_PCH | write return address high byte to the stack
// PUSH_PCL | write return address low byte to the stack
// PUSH_P   | write status byte (B marks BRK), set I on advance
// VEC_LO   | read vector low byte
// VEC_HI   | read vector high byte
// LOAD     | hand the assembled vector to the PC, then release the bus
module interrupt_sequencer (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          irq_n,
    input  logic                          nmi_n,
    input  logic                          brk_req,
    input  logic                          instr_done,
    input  logic [7:0]                    psr_in,
    input  logic [15:0]                   pc_in,
    input  logic [7:0]                    sp_in,
    interrupt_sequencer_if.master         bus,
    output logic                          busy,
    output logic                          sp_dec,
    output logic                          set_i,
    output logic                          pc_load,
    output logic [15:0]                   pc_vec,
    output logic                          done
);
    localparam logic [15:0] NMI_VEC = 16'hFFFA;
    localparam logic [15:0] IRQ_VEC = 16'hFFFE;

    typedef enum logic [2:0] {
        IDLE, PUSH_PCH, PUSH_PCL, PUSH_P, VEC_LO, VEC_HI, LOAD
    } state_t;

    typedef enum logic [1:0] {SRC_NMI, SRC_BRK, SRC_IRQ} src_t;

    state_t      state, state_n;
    src_t        src, accept_src;
    logic        accept;
    logic [15:0] pc_l;
    logic [7:0]  sp_l;
    logic [7:0]  p_l;
    logic [7:0]  vec_lo, vec_hi;
    logic        nmi_prev, nmi_pend;
    logic        sp_dec_q, set_i_q;
    logic        push_adv, p_adv, lo_adv, hi_adv;
    logic [15:0] addr_c;
    logic [7:0]  data_c;
    logic        rw_c;
    logic [15:0] vec_base;
    logic        unused_psr;

    assign unused_psr = ^psr_in[5:4];
    assign vec_base   = (src == SRC_NMI) ? NMI_VEC : IRQ_VEC;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            src      <= SRC_IRQ;
            pc_l     <= 16'h0000;
            sp_l     <= 8'h00;
            p_l      <= 8'h00;
            vec_lo   <= 8'h00;
            vec_hi   <= 8'h00;
            nmi_prev <= 1'b1;
            nmi_pend <= 1'b0;
            sp_dec_q <= 1'b0;
            set_i_q  <= 1'b0;
        end else begin
            state    <= state_n;
            nmi_prev <= nmi_n;
            sp_dec_q <= push_adv;
            set_i_q  <= p_adv;
            // a new falling edge wins over the clear of the NMI being accepted
            if (accept && accept_src == SRC_NMI)
                nmi_pend <= 1'b0;
            if (nmi_prev && !nmi_n)
                nmi_pend <= 1'b1;
            if (accept) begin
                src  <= accept_src;
                pc_l <= pc_in;
                sp_l <= sp_in;
                p_l  <= {psr_in[7:6], 1'b1, (accept_src == SRC_BRK), psr_in[3:0]};
            end
            if (push_adv)
                sp_l <= sp_l - 8'd1;
            if (lo_adv)
                vec_lo <= bus.data_in;
            if (hi_adv)
                vec_hi <= bus.data_in;
        end
    end

    always_comb begin
        state_n    = state;
        accept     = 1'b0;
        accept_src = SRC_IRQ;
        push_adv   = 1'b0;
        p_adv      = 1'b0;
        lo_adv     = 1'b0;
        hi_adv     = 1'b0;
        addr_c     = 16'h0000;
        data_c     = 8'h00;
        rw_c       = 1'b1;
        busy       = 1'b1;
        pc_load    = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (instr_done) begin
                    if (nmi_pend) begin
                        accept     = 1'b1;
                        accept_src = SRC_NMI;
                    end else if (brk_req) begin
                        accept     = 1'b1;
                        accept_src = SRC_BRK;
                    end else if (!irq_n && !psr_in[2]) begin
                        accept     = 1'b1;
                        accept_src = SRC_IRQ;
                    end
                end
                if (accept)
                    state_n = PUSH_PCH;
            end
            PUSH_PCH, PUSH_PCL, PUSH_P: begin
                rw_c   = 1'b0;
                addr_c = {8'h01, sp_l};
                data_c = (state == PUSH_PCH) ? pc_l[15:8] :
                         (state == PUSH_PCL) ? pc_l[7:0]  : p_l;
                if (bus.ready) begin
                    push_adv = 1'b1;
                    case (state)
                        PUSH_PCH: state_n = PUSH_PCL;
                        PUSH_PCL: state_n = PUSH_P;
                        default: begin
                            p_adv   = 1'b1;
                            state_n = VEC_LO;
                        end
                    endcase
                end
            end
            VEC_LO: begin
                addr_c = vec_base;
                if (bus.ready) begin
                    lo_adv  = 1'b1;
                    state_n = VEC_HI;
                end
            end
            VEC_HI: begin
                addr_c = vec_base + 16'd1;
                if (bus.ready) begin
                    hi_adv  = 1'b1;
                    state_n = LOAD;
                end
            end
            LOAD: begin
                pc_load = 1'b1;
                done    = 1'b1;
                state_n = IDLE;
            end
            default: begin
                busy    = 1'b0;
                state_n = IDLE;
            end
        endcase
    end

    assign bus.addr_out = addr_c;
    assign bus.data_out = data_c;
    assign bus.rw       = rw_c;
    assign sp_dec       = sp_dec_q;
    assign set_i        = set_i_q;
    assign pc_vec       = {vec_hi, vec_lo};
endmodule

// File: tb/tb_interrupt_sequencer.sv
// Scoreboard bench: a cycle-level request/arbitration model pushes the expected bus
// transactions at acceptance; a negedge monitor compares whatever the DUT presents.
module tb_interrupt_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic        irq_n, nmi_n, brk_req, instr_done, ready_tb;
    logic [7:0]  psr_in, sp_in;
    logic [15:0] pc_in;
    logic        busy, sp_dec, set_i, pc_load, done;
    logic [15:0] pc_vec;
    logic [7:0]  nv_lo, nv_hi, iv_lo, iv_hi;

    interrupt_sequencer_if bus();

    interrupt_sequencer dut (
        .clk(clk), .rst(rst), .irq_n(irq_n), .nmi_n(nmi_n), .brk_req(brk_req),
        .instr_done(instr_done), .psr_in(psr_in), .pc_in(pc_in), .sp_in(sp_in),
        .bus(bus), .busy(busy), .sp_dec(sp_dec), .set_i(set_i), .pc_load(pc_load),
        .pc_vec(pc_vec), .done(done)
    );

    always #5 clk = ~clk;

    assign bus.ready   = ready_tb;
    assign bus.data_in = (bus.addr_out == 16'hFFFA) ? nv_lo :
                         (bus.addr_out == 16'hFFFB) ? nv_hi :
                         (bus.addr_out == 16'hFFFE) ? iv_lo :
                         (bus.addr_out == 16'hFFFF) ? iv_hi : 8'h5A;

    typedef struct {
        bit          is_load;
        bit          rw;
        logic [15:0] addr;
        logic [7:0]  data;
        logic [15:0] vec;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   checking = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: pending NMI, priority arbitration, and beat counting
    bit m_busy, m_pend, m_prev;
    int m_beats, m_stalls;

    always @(posedge clk) begin
        int          src;
        logic [15:0] base;
        logic [7:0]  pv, s1, s2, lo, hi;
        bit          fall;
        if (rst) begin
            m_busy = 0;
            m_pend = 0;
            m_prev = 1;
            q.delete();
        end else begin
            fall = m_prev && !nmi_n;
            if (!m_busy) begin
                src = 0;
                if (instr_done) begin
                    if (m_pend) src = 1;
                    else if (brk_req) src = 2;
                    else if (!irq_n && !psr_in[2]) src = 3;
                end
                if (src != 0) begin
                    base = (src == 1) ? 16'hFFFA : 16'hFFFE;
                    lo   = (src == 1) ? nv_lo : iv_lo;
                    hi   = (src == 1) ? nv_hi : iv_hi;
                    pv   = (psr_in & 8'hCF) | 8'h20 | ((src == 2) ? 8'h10 : 8'h00);
                    s1   = sp_in - 8'd1;
                    s2   = sp_in - 8'd2;
                    q.push_back('{is_load: 0, rw: 0, addr: {8'h01, sp_in}, data: pc_in[15:8], vec: 16'h0});
                    q.push_back('{is_load: 0, rw: 0, addr: {8'h01, s1}, data: pc_in[7:0], vec: 16'h0});
                    q.push_back('{is_load: 0, rw: 0, addr: {8'h01, s2}, data: pv, vec: 16'h0});
                    q.push_back('{is_load: 0, rw: 1, addr: base, data: 8'h00, vec: 16'h0});
                    q.push_back('{is_load: 0, rw: 1, addr: base + 16'd1, data: 8'h00, vec: 16'h0});
                    q.push_back('{is_load: 1, rw: 1, addr: 16'h0, data: 8'h00, vec: {hi, lo}});
                    m_busy   = 1;
                    m_beats  = 5;
                    m_stalls = 0;
                    if (src == 1) m_pend = 0;
                end
            end else if (m_beats > 0) begin
                if (ready_tb) m_beats--;
                else m_stalls++;
            end else begin
                m_busy = 0;
            end
            if (fall) m_pend = 1;
            m_prev = nmi_n;
        end
    end

    // monitor
    int busy_len = 0, sp_cnt = 0, si_cnt = 0;

    always @(negedge clk) begin
        exp_t h;
        if (checking) begin
            chk("busy", busy, m_busy);
            if (!busy) begin
                chk("idle_outputs", {bus.addr_out, bus.data_out, bus.rw, sp_dec, set_i, pc_load, done},
                    {16'h0000, 8'h00, 1'b1, 4'b0000});
                busy_len = 0;
                sp_cnt   = 0;
                si_cnt   = 0;
            end else begin
                busy_len++;
                sp_cnt += int'(sp_dec);
                si_cnt += int'(set_i);
                if (q.size() == 0) begin
                    chk("unexpected_busy_cycle", 1, 0);
                end else if (pc_load) begin
                    h = q.pop_front();
                    chk("load_expected", 1, h.is_load);
                    chk("pc_vec", pc_vec, h.vec);
                    chk("done_with_load", done, 1);
                    chk("sp_dec_count", sp_cnt, 3);
                    chk("set_i_count", si_cnt, 1);
                    chk("busy_length", busy_len, 6 + m_stalls);
                end else begin
                    h = q[0];
                    chk("load_early", 0, h.is_load);
                    chk("done_early", done, 0);
                    chk("bus_rw", bus.rw, h.rw);
                    chk("bus_addr", bus.addr_out, h.addr);
                    if (!h.rw) chk("bus_data", bus.data_out, h.data);
                    if (ready_tb) void'(q.pop_front());
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || m_busy) && n < 60) begin
            step();
            n++;
        end
        if (n >= 60) chk("wait_idle_timeout", n, 0);
    endtask

    task automatic issue_brk(input logic [7:0] sp, input logic [15:0] pc, input logic [7:0] psr);
        sp_in = sp; pc_in = pc; psr_in = psr;
        brk_req = 1; instr_done = 1;
        step();
        brk_req = 0; instr_done = 0;
        pc_in = ~pc; psr_in = ~psr; sp_in = ~sp;
    endtask

    initial begin
        rst = 1; irq_n = 1; nmi_n = 1; brk_req = 0; instr_done = 0; ready_tb = 1;
        psr_in = 8'h00; sp_in = 8'hFF; pc_in = 16'h0000;
        nv_lo = 8'h34; nv_hi = 8'hC2; iv_lo = 8'h00; iv_hi = 8'h80;
        step();
        step();
        rst = 0;
        checking = 1;
        chk("reset_pc_vec", pc_vec, 16'h0000);

        // BRK with the reference numbers
        issue_brk(8'hFD, 16'h1234, 8'h81);
        wait_idle();
        chk("brk_vector", pc_vec, 16'h8000);

        // masked IRQ, then unmasked
        irq_n = 0; psr_in = 8'h04; instr_done = 1;
        repeat (8) step();
        chk("masked_irq_idle", busy, 0);
        psr_in = 8'h00; sp_in = 8'h80; pc_in = 16'hBEEF;
        step();
        instr_done = 0; irq_n = 1;
        wait_idle();

        // NMI beats IRQ; new edge during the sequence gives a second NMI
        irq_n = 0; nmi_n = 0;
        step();
        instr_done = 1; sp_in = 8'h40;
        step();
        instr_done = 0; irq_n = 1;
        step();
        nmi_n = 1;
        step();
        nmi_n = 0;
        wait_idle();
        chk("nmi_vector", pc_vec, {nv_hi, nv_lo});
        instr_done = 1;
        step();
        instr_done = 0;
        wait_idle();
        instr_done = 1;
        repeat (8) step();
        chk("nmi_held_no_retrigger", busy, 0);
        instr_done = 0; nmi_n = 1;
        step();

        // stall three cycles in PUSH_PCL
        issue_brk(8'hC0, 16'h5678, 8'h00);
        step();
        ready_tb = 0;
        repeat (3) step();
        ready_tb = 1;
        wait_idle();

        // SP wrap
        issue_brk(8'h01, 16'hA55A, 8'hCF);
        wait_idle();

        // reset in VEC_LO with an NMI pending
        issue_brk(8'hF0, 16'h0F0F, 8'h00);
        nmi_n = 0;
        step();
        step();
        step();
        rst = 1; nmi_n = 1;
        step();
        rst = 0;
        chk("reset_abort_busy", busy, 0);
        chk("reset_abort_rw", bus.rw, 1);
        chk("reset_abort_load", pc_load, 0);
        instr_done = 1;
        repeat (4) step();
        chk("reset_cleared_nmi", busy, 0);
        instr_done = 0;

        // randomized traffic
        nv_lo = 8'($urandom); nv_hi = 8'($urandom);
        iv_lo = 8'($urandom); iv_hi = 8'($urandom);
        for (int i = 0; i < 1500; i++) begin
            instr_done = ($urandom_range(0, 1) == 1);
            brk_req    = ($urandom_range(0, 4) == 0);
            irq_n      = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0) nmi_n = ~nmi_n;
            ready_tb   = ($urandom_range(0, 4) != 0);
            psr_in     = 8'($urandom);
            pc_in      = 16'($urandom);
            sp_in      = 8'($urandom);
            step();
        end
        instr_done = 0; brk_req = 0; irq_n = 1; ready_tb = 1;
        wait_idle();
        step();
        chk("queue_drained", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
